ah_packet_converter_w2n: RTL and testbench
==========================================

AH_PACKET_CONVERTER_W2N -- requirements
Module: ah_packet_converter_w2n

Interface
REQ-001 Parameter NARROW_W, default 10: output beat width in bits.
REQ-002 Parameter RATIO, default 3: narrow beats per wide word, minimum 2.
REQ-003 Parameter WIDE_W, default 30: input word width in bits; SHALL equal NARROW_W*RATIO, elaboration error otherwise.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 rdata  input  WIDE_W  wide word from upstream.
REQ-007 rvalid  input  1  rdata valid.
REQ-008 rready  output  1  block accepts rdata this cycle.
REQ-009 wdata  output  NARROW_W  narrow beat to downstream.
REQ-010 wvalid  output  1  wdata valid.
REQ-011 wready  input  1  downstream accepts wdata this cycle.
REQ-012 wlast  output  1  current beat is final lane of its wide word.

Function
REQ-013 Transfer on either side SHALL occur only when valid and ready are both high at a rising clk edge.
REQ-014 FSM SHALL have two states: EMPTY (no word held) and SEND (word held in a WIDE_W holding register).
REQ-015 EMPTY: rready=1, wvalid=0; rvalid high SHALL capture rdata, clear lane to 0, go to SEND.
REQ-016 SEND: wvalid=1; wdata SHALL equal holding[lane*NARROW_W +: NARROW_W], lane 0 (LSBs) first.
REQ-017 wlast SHALL be 1 only in SEND with lane==RATIO-1; 0 otherwise.
REQ-018 SEND with wready=1 and lane<RATIO-1: lane SHALL increment by 1; holding unchanged.
REQ-019 SEND with wready=0: lane, holding, wdata SHALL remain stable (no beat dropped or repeated).
REQ-020 rready in SEND SHALL be (lane==RATIO-1) && wready, combinational from wready only.
REQ-021 Final beat accepted with rvalid=1: next word SHALL be captured same edge, lane to 0, stay SEND (no bubble).
REQ-022 Final beat accepted with rvalid=0: go to EMPTY; lane to 0.
REQ-023 Latency: word accepted at edge T SHALL present lane 0 on wdata from T+1; sustained throughput one narrow beat per cycle.
REQ-024 Lane counter width SHALL be $clog2(RATIO); lane SHALL never exceed RATIO-1 (wrap to 0 only via REQ-021/022).
REQ-025 rvalid, rdata SHALL be ignored whenever rready=0.
REQ-026 wdata SHALL be 0 in EMPTY.

Reset
REQ-027 rstn low SHALL immediately force EMPTY, lane=0, holding=0, wvalid=0, wlast=0, wdata=0, rready=1 once rstn deasserts.
REQ-028 Reset mid-word SHALL discard remaining lanes; no partial beats SHALL be emitted after release.
REQ-029 Release SHALL be synchronized by the integrator; block SHALL function from first edge after rstn high.

Structure
REQ-030 Shared package ah_pkt_conv_pkg SHALL hold default width constants and the state enum (EMPTY, SEND), shared with the narrow-to-wide converter.
REQ-031 Lane counter SHALL be sub-module ah_lane_counter (modulo-RATIO counter, inc and clear inputs, last-flag output).
REQ-032 Holding register and FSM SHALL reside in ah_packet_converter_w2n; no other sub-modules.

Verification
REQ-033 Single word: rdata=30'h3C3556AA, wready=1 -> wdata 10'h2AA, 10'h155, 10'h3C3 on three consecutive cycles, wlast on third only, then wvalid=0.
REQ-034 Back-to-back: two words presented continuously, wready=1 -> six beats in six consecutive cycles, rready high only on each final-lane cycle.
REQ-035 Backpressure: wready=0 for 4 cycles during lane 1 -> wdata held at lane-1 value, lane unchanged, rready=0, no loss after wready returns.
REQ-036 Reset mid-word: rstn low after lane 0 accepted -> wvalid=0 immediately; after release, next word starts at lane 0.
REQ-037 Random valid/ready toggling, 1000 words -> scoreboard reassembly of narrow beats matches every input word, lane order LSB-first.
REQ-038 Idle: rvalid=0 after reset for 10 cycles -> rready=1, wvalid=0, wdata=0 throughout.

Source files
------------

// File: rtl/ah_pkt_conv_pkg.sv
// ah_pkt_conv_pkg
// Shared definitions for the wide/narrow packet converters: default width
// constants, the two-state converter FSM encoding, and a helper that sizes
// the lane counter.
// Ports: none (package).
package ah_pkt_conv_pkg;

  localparam int DEF_NARROW_W = 10;
  localparam int DEF_RATIO    = 3;
  localparam int DEF_WIDE_W   = DEF_NARROW_W * DEF_RATIO;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } conv_state_t;

  // Lane counter needs at least one bit even for degenerate ratios.
  function automatic int lane_bits(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/ah_lane_counter.sv
// ah_lane_counter
// Modulo-RATIO lane index for the width converters.
// Ports:
//   clk, rstn : clock, async active-low reset
//   inc       : advance to the next lane (wraps after RATIO-1)
//   clr       : return to lane 0, takes priority over inc
//   lane      : current lane index
//   last      : lane is the final lane (RATIO-1)
module ah_lane_counter
  import ah_pkt_conv_pkg::*;
#(
  parameter int RATIO  = DEF_RATIO,
  parameter int LANE_W = lane_bits(RATIO)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inc,
  input  logic              clr,
  output logic [LANE_W-1:0] lane,
  output logic              last
);

  assign last = (lane == LANE_W'(RATIO - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane <= '0;
    end else if (clr) begin
      lane <= '0;
    end else if (inc) begin
      lane <= last ? '0 : lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/ah_packet_converter_w2n.sv
// ah_packet_converter_w2n
// Splits each WIDE_W word into RATIO narrow beats, lane 0 (LSBs) first.
// A single holding register is refilled on the same edge that the final
// beat leaves, so back-to-back words stream with no bubble.
// Ports:
//   clk, rstn     : clock, async active-low reset
//   rdata/rvalid  : wide word from upstream
//   rready        : block accepts rdata this cycle
//   wdata/wvalid  : narrow beat to downstream
//   wready        : downstream accepts wdata this cycle
//   wlast         : current beat is the final lane of its word
//
// state | meaning
// EMPTY | no word held, waiting for rvalid
// SEND  | word held, presenting holding lane by lane
module ah_packet_converter_w2n
  import ah_pkt_conv_pkg::*;
#(
  parameter int NARROW_W = DEF_NARROW_W,
  parameter int RATIO    = DEF_RATIO,
  parameter int WIDE_W   = DEF_WIDE_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WIDE_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [NARROW_W-1:0] wdata,
  output logic                wvalid,
  input  logic                wready,
  output logic                wlast
);

  localparam int LANE_W = lane_bits(RATIO);

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("ah_packet_converter_w2n: RATIO must be at least 2");
    end
    if (WIDE_W != NARROW_W * RATIO) begin : g_bad_width
      $error("ah_packet_converter_w2n: WIDE_W must equal NARROW_W*RATIO");
    end
  endgenerate

  conv_state_t         state;
  conv_state_t         state_nxt;
  logic [WIDE_W-1:0]   holding;
  logic [LANE_W-1:0]   lane;
  logic                lane_last;
  logic                lane_inc;
  logic                lane_clr;
  logic                load;
  logic [NARROW_W-1:0] lane_data;

  ah_lane_counter #(
    .RATIO  (RATIO),
    .LANE_W (LANE_W)
  ) u_lane (
    .clk  (clk),
    .rstn (rstn),
    .inc  (lane_inc),
    .clr  (lane_clr),
    .lane (lane),
    .last (lane_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      holding <= '0;
    end else if (load) begin
      holding <= rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    rready    = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    lane_inc  = 1'b0;
    lane_clr  = 1'b0;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        rready = 1'b1;
        if (rvalid) begin
          load      = 1'b1;
          lane_clr  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        wvalid = 1'b1;
        wlast  = lane_last;
        // Only the final beat frees the holding register, so upstream is
        // offered a slot exactly when that beat is being taken.
        rready = lane_last && wready;
        if (wready) begin
          if (lane_last) begin
            lane_clr = 1'b1;
            if (rvalid) begin
              load = 1'b1;
            end else begin
              state_nxt = EMPTY;
            end
          end else begin
            lane_inc = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) begin
        lane_data = holding[i*NARROW_W +: NARROW_W];
      end
    end
  end

  assign wdata = (state == SEND) ? lane_data : '0;

endmodule

// File: tb/tb_ah_packet_converter_w2n.sv
// tb_ah_packet_converter_w2n
// Self-checking bench: directed scenarios with inline checks plus a
// scoreboard that expands every accepted wide word into its expected beats.
module tb_ah_packet_converter_w2n;

  localparam int NW = 10;
  localparam int R  = 3;
  localparam int WW = 30;

  typedef struct packed {
    logic [NW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [WW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic [NW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          wlast;

  int    errors = 0;
  int    checks = 0;
  beat_t sbq[$];
  beat_t exp_b;

  always #5 clk = ~clk;

  ah_packet_converter_w2n #(
    .NARROW_W (NW),
    .RATIO    (R),
    .WIDE_W   (WW)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rready (rready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .wlast  (wlast)
  );

  function automatic logic [NW-1:0] lane_of(input logic [WW-1:0] w, input int l);
    return NW'(w >> (l * NW));
  endfunction

  // Scoreboard: sampled mid-cycle, so the handshakes seen here are the
  // ones the next rising edge will commit.
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
    end else begin
      if (wvalid && wready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_beat: got wdata=%h wlast=%b, no beat expected", wdata, wlast);
        end else begin
          exp_b = sbq.pop_front();
          if (wdata !== exp_b.data || wlast !== exp_b.last) begin
            errors++;
            $display("FAIL sb_beat: got wdata=%h wlast=%b, expected wdata=%h wlast=%b",
                     wdata, wlast, exp_b.data, exp_b.last);
          end
        end
      end else if (!wvalid) begin
        checks++;
        if (wdata !== '0 || wlast !== 1'b0) begin
          errors++;
          $display("FAIL sb_idle_outputs: got wdata=%h wlast=%b, expected 0/0", wdata, wlast);
        end
      end
      if (rvalid && rready) begin
        for (int l = 0; l < R; l++) begin
          sbq.push_back('{data: lane_of(rdata, l), last: (l == R - 1)});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    rvalid = 1'b0;
    wready = 1'b0;
    rdata  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (rready !== 1'b1 || wvalid !== 1'b0 || wlast !== 1'b0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rready=%b wvalid=%b wlast=%b wdata=%h, expected 1 0 0 000",
               rready, wvalid, wlast, wdata);
    end
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_idle();
    rvalid = 1'b0;
    wready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rready !== 1'b1 || wvalid !== 1'b0 || wdata !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got rready=%b wvalid=%b wdata=%h, expected 1 0 000",
                 i, rready, wvalid, wdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_word();
    logic [NW-1:0] exp_d [3];
    exp_d[0] = 10'h2AA;
    exp_d[1] = 10'h155;
    exp_d[2] = 10'h3C3;
    rdata  = 30'h3C3556AA;
    rvalid = 1'b1;
    wready = 1'b1;
    @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got rready=%b, expected 1", rready);
    end
    next_cycle();
    rvalid = 1'b0;
    rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (wvalid !== 1'b1 || wdata !== exp_d[i] || wlast !== (i == 2)) begin
        errors++;
        $display("FAIL single_beat%0d: got wvalid=%b wdata=%h wlast=%b, expected 1 %h %b",
                 i, wvalid, wdata, wlast, exp_d[i], (i == 2));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got wvalid=%b, expected 0", wvalid);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] wa;
    logic [WW-1:0] wb;
    logic [WW-1:0] wcur;
    wa     = WW'($urandom);
    wb     = WW'($urandom);
    rdata  = wa;
    rvalid = 1'b1;
    wready = 1'b1;
    @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_first: got rready=%b, expected 1", rready);
    end
    next_cycle();
    rdata = wb;
    for (int i = 0; i < 6; i++) begin
      wcur = (i < 3) ? wa : wb;
      @(negedge clk);
      checks++;
      if (wvalid !== 1'b1 || rready !== (i % 3 == 2) || wdata !== lane_of(wcur, i % 3)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got wvalid=%b rready=%b wdata=%h, expected 1 %b %h",
                 i, wvalid, rready, wdata, (i % 3 == 2), lane_of(wcur, i % 3));
      end
      next_cycle();
      if (i == 2) rvalid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got wvalid=%b, expected 0", wvalid);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] w;
    w      = WW'($urandom);
    rdata  = w;
    rvalid = 1'b1;
    wready = 1'b1;
    next_cycle();
    rdata = ~w;
    @(negedge clk);
    checks++;
    if (wdata !== lane_of(w, 0)) begin
      errors++;
      $display("FAIL bp_lane0: got wdata=%h, expected %h", wdata, lane_of(w, 0));
    end
    next_cycle();
    wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (wvalid !== 1'b1 || wdata !== lane_of(w, 1) || rready !== 1'b0 || wlast !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got wvalid=%b wdata=%h rready=%b wlast=%b, expected 1 %h 0 0",
                 i, wvalid, wdata, rready, wlast, lane_of(w, 1));
      end
      next_cycle();
    end
    wready = 1'b1;
    rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wdata !== lane_of(w, 1) || wlast !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume_lane1: got wdata=%h wlast=%b, expected %h 0", wdata, wlast, lane_of(w, 1));
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (wdata !== lane_of(w, 2) || wlast !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume_lane2: got wdata=%h wlast=%b, expected %h 1", wdata, wlast, lane_of(w, 2));
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: got wvalid=%b, expected 0", wvalid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_word();
    logic [WW-1:0] w;
    logic [WW-1:0] w2;
    w      = WW'($urandom);
    w2     = WW'($urandom);
    rdata  = w;
    rvalid = 1'b1;
    wready = 1'b1;
    next_cycle();
    rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wdata !== lane_of(w, 0)) begin
      errors++;
      $display("FAIL rmw_lane0: got wdata=%h, expected %h", wdata, lane_of(w, 0));
    end
    next_cycle();
    rstn = 1'b0;
    #1;
    checks++;
    if (wvalid !== 1'b0 || wdata !== '0 || wlast !== 1'b0) begin
      errors++;
      $display("FAIL rmw_async: got wvalid=%b wdata=%h wlast=%b, expected 0 000 0", wvalid, wdata, wlast);
    end
    @(negedge clk);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0 || rready !== 1'b1) begin
      errors++;
      $display("FAIL rmw_after_release: got wvalid=%b rready=%b, expected 0 1", wvalid, rready);
    end
    next_cycle();
    rdata  = w2;
    rvalid = 1'b1;
    next_cycle();
    rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b1 || wdata !== lane_of(w2, 0) || wlast !== 1'b0) begin
      errors++;
      $display("FAIL rmw_new_lane0: got wvalid=%b wdata=%h wlast=%b, expected 1 %h 0",
               wvalid, wdata, wlast, lane_of(w2, 0));
    end
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (wvalid !== 1'b0) begin
      errors++;
      $display("FAIL rmw_done: got wvalid=%b, expected 0", wvalid);
    end
    next_cycle();
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    bit acc;
    sent   = 0;
    cyc    = 0;
    rdata  = WW'($urandom);
    rvalid = 1'b1;
    wready = 1'b1;
    while ((sent < 1000 || sbq.size() != 0 || wvalid) && cyc < 30000) begin
      @(negedge clk);
      acc = rvalid && rready;
      next_cycle();
      cyc++;
      if (acc) begin
        sent++;
        rdata = WW'($urandom);
      end
      rvalid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      wready = ($urandom_range(0, 3) != 0);
    end
    rvalid = 1'b0;
    wready = 1'b1;
    checks++;
    if (sent != 1000 || sbq.size() != 0) begin
      errors++;
      $display("FAIL random_complete: got %0d words sent, %0d beats outstanding after %0d cycles, expected 1000 and 0",
               sent, sbq.size(), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    repeat (2) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
